gpio_debounce: RTL and testbench
================================

GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 2: number of GPIO input words; matches the GPIO peripheral's port count.
REQ-002 The block SHALL have parameter WIDTH, default 32: bits per word.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable ticks required to accept a new level; legal range >= 1.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 tick  input  1  debounce count enable (prescaler strobe); tie to 1 for per-cycle counting.
REQ-007 pin  input  [CHANNELS][WIDTH]  raw asynchronous pad inputs.
REQ-008 level  output  [CHANNELS][WIDTH]  debounced registered level; drives the GPIO peripheral's in port.
REQ-009 rise  output  [CHANNELS][WIDTH]  one-cycle pulse per bit on accepted 0->1.
REQ-010 fall  output  [CHANNELS][WIDTH]  one-cycle pulse per bit on accepted 1->0.
REQ-011 evt_clr  input  [CHANNELS][WIDTH]  write-1-to-clear for sticky event bits.
REQ-012 evt  output  [CHANNELS][WIDTH]  sticky flag, set by any rise or fall.
REQ-013 irq_en  input  [CHANNELS][WIDTH]  per-bit interrupt mask.
REQ-014 irq  output  1  registered OR over all bits of (evt AND irq_en).

Function
REQ-015 Each bit SHALL pass through a 2-flop synchronizer (s1, s2) before any other logic.
REQ-016 Each bit SHALL hold a counter cnt of width $clog2(DEBOUNCE_CYCLES+1), saturating-free, never exceeding DEBOUNCE_CYCLES-1.
REQ-017 States per bit: STABLE (s2 == level, cnt = 0) and PENDING (s2 != level).
REQ-018 STABLE -> PENDING when s2 != level; cnt unchanged at 0 on that edge unless tick is high, in which case cnt increments.
REQ-019 In PENDING, when s2 == level on any cycle (tick irrelevant), cnt SHALL clear to 0 and state SHALL return to STABLE (glitch rejected, no pulse).
REQ-020 In PENDING with tick high and cnt == DEBOUNCE_CYCLES-1, level SHALL take s2, cnt SHALL clear, and rise or fall SHALL be 1 in the following cycle only.
REQ-021 In PENDING with tick high and cnt < DEBOUNCE_CYCLES-1, cnt SHALL increment by 1; tick low holds cnt.
REQ-022 Latency with tick tied high: level changes DEBOUNCE_CYCLES+2 rising edges after the first edge sampling the new pin value (3 edges for DEBOUNCE_CYCLES = 1).
REQ-023 rise and fall SHALL never both be 1 for the same bit in the same cycle.
REQ-024 evt bit SHALL set on the cycle rise|fall is 1; evt_clr clears it; simultaneous set and clear SHALL leave it set.
REQ-025 irq SHALL reflect evt and irq_en with one cycle of register latency.
REQ-026 Bits SHALL be fully independent; no cross-bit interaction except irq reduction.

Reset
REQ-027 While rst is high, s1, s2, level, cnt, rise, fall, evt and irq SHALL all be 0 on the next edge.
REQ-028 Reset asserted mid-PENDING SHALL abandon the count; after release a high pin requires the full REQ-022 latency to appear on level.

Structure
REQ-029 Parameter defaults and the per-bit state enum SHALL live in shared package gpio_pkg.
REQ-030 Per-bit logic (sync, counter, edge, sticky) SHALL be sub-module gpio_debounce_bit, instantiated CHANNELS*WIDTH times by generate; top adds only the irq reduction.

Verification
REQ-031 DEBOUNCE_CYCLES=4, tick=1, pin[0][0] 0->1 held -> level[0][0]=1 after exactly 6 edges, rise[0][0] high exactly 1 cycle, evt[0][0]=1.
REQ-032 DEBOUNCE_CYCLES=4, pin[1][5] high 3 cycles then low -> level, rise, evt unchanged.
REQ-033 tick high every 4th cycle, DEBOUNCE_CYCLES=4 -> level updates only after 4 tick cycles of stable mismatch; glitch during tick-low cycles still clears cnt.
REQ-034 evt[0][3]=1, irq_en[0][3]=1 -> irq=1 next cycle; evt_clr[0][3]=1 coincident with a new fall -> evt stays 1.
REQ-035 rst pulsed at cnt=2 with pin held high -> all outputs 0; level rises 6 edges after rst deasserts.
REQ-036 DEBOUNCE_CYCLES=1, all 64 bits toggled together -> all rise pulses coincide, 3 edges latency, no fall.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO input debouncer: parameter defaults,
// the per-bit debounce state and a counter sizing helper.
package gpio_pkg;

  // Defaults match the GPIO peripheral this block feeds.
  localparam int unsigned CHANNELS_DEF        = 2;
  localparam int unsigned WIDTH_DEF           = 32;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

  // A bit is STABLE while its synchronized input equals the accepted level,
  // PENDING while the two disagree and the stability count is running.
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } deb_state_e;

  // Counter width able to hold DEBOUNCE_CYCLES; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    if (cycles < 1) begin
      return 1;
    end
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_debounce_if.sv
// Bundle of the debouncer's word-wide signals. The master side (the GPIO
// peripheral or a testbench) drives pads, tick strobe, clear and mask; the
// slave side (the debouncer) returns the debounced level, edge pulses,
// sticky events, the interrupt and a per-bit PENDING debug view.
//
// Signalling: there is no valid/ready handshake. tick is a level-sampled
// strobe: every rising clk edge with tick high counts as one debounce tick.
// evt_clr is write-1-to-clear and takes effect on the edge it is sampled
// high; a set arriving on that same edge wins. rise/fall are single-cycle
// pulses and are never held.
interface gpio_debounce_if
  import gpio_pkg::*;
#(
  parameter int unsigned CHANNELS = CHANNELS_DEF,
  parameter int unsigned WIDTH    = WIDTH_DEF
);

  logic                           tick;
  logic [CHANNELS-1:0][WIDTH-1:0] pin;
  logic [CHANNELS-1:0][WIDTH-1:0] evt_clr;
  logic [CHANNELS-1:0][WIDTH-1:0] irq_en;
  logic [CHANNELS-1:0][WIDTH-1:0] level;
  logic [CHANNELS-1:0][WIDTH-1:0] rise;
  logic [CHANNELS-1:0][WIDTH-1:0] fall;
  logic [CHANNELS-1:0][WIDTH-1:0] evt;
  logic [CHANNELS-1:0][WIDTH-1:0] pending;
  logic                           irq;

  modport master (
    output tick,
    output pin,
    output evt_clr,
    output irq_en,
    input  level,
    input  rise,
    input  fall,
    input  evt,
    input  pending,
    input  irq
  );

  modport slave (
    input  tick,
    input  pin,
    input  evt_clr,
    input  irq_en,
    output level,
    output rise,
    output fall,
    output evt,
    output pending,
    output irq
  );

endinterface

// File: rtl/gpio_debounce_bit.sv
// One debounced GPIO bit: two-flop synchronizer, tick-driven stability
// counter, registered edge pulses and a sticky event flag.
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic pin_i,
  input  logic evt_clr_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic evt_o,
  output logic pending_o
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          s1_q;
  logic          s2_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          rise_q;
  logic          rise_d;
  logic          fall_q;
  logic          fall_d;
  logic          evt_q;
  logic          evt_d;
  deb_state_e    state;

  // Bring the asynchronous pad into the clk domain before anything looks at it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pin_i;
      s2_q <= s1_q;
    end
  end

  // Decode state from the synchronized input versus the accepted level, then
  // advance the stability count and decide whether to accept the new level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    state   = (s2_q != level_q) ? ST_PENDING : ST_STABLE;

    case (state)
      ST_STABLE: begin
        // Any earlier mismatch was a glitch; the next one starts from zero.
        cnt_d = '0;
      end
      ST_PENDING: begin
        if (tick_i) begin
          if (cnt_q == CNT_LAST) begin
            level_d = s2_q;
            cnt_d   = '0;
            rise_d  = s2_q;
            fall_d  = ~s2_q;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase

    // The sticky flag picks up the pulse that is visible this cycle, so a
    // clear arriving together with that pulse cannot swallow it.
    evt_d = (evt_q & ~evt_clr_i) | rise_q | fall_q;
  end

  // Debounce state, edge pulses and sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      evt_q   <= evt_d;
    end
  end

  assign level_o   = level_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign evt_o     = evt_q;
  assign pending_o = (state == ST_PENDING);

endmodule

// File: rtl/gpio_debounce.sv
// Word-parallel GPIO input debouncer. Each pad bit is handled by its own
// gpio_debounce_bit; the only shared logic is the registered interrupt
// reduction over the enabled sticky events.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned CHANNELS        = CHANNELS_DEF,
  parameter int unsigned WIDTH           = WIDTH_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  gpio_debounce_if.slave bus
);

  logic [CHANNELS-1:0][WIDTH-1:0] level_w;
  logic [CHANNELS-1:0][WIDTH-1:0] rise_w;
  logic [CHANNELS-1:0][WIDTH-1:0] fall_w;
  logic [CHANNELS-1:0][WIDTH-1:0] evt_w;
  logic [CHANNELS-1:0][WIDTH-1:0] pending_w;
  logic                           irq_q;
  logic                           irq_d;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      gpio_debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
        .clk       (clk),
        .rst       (rst),
        .tick_i    (bus.tick),
        .pin_i     (bus.pin[ch][b]),
        .evt_clr_i (bus.evt_clr[ch][b]),
        .level_o   (level_w[ch][b]),
        .rise_o    (rise_w[ch][b]),
        .fall_o    (fall_w[ch][b]),
        .evt_o     (evt_w[ch][b]),
        .pending_o (pending_w[ch][b])
      );
    end
  end

  // Any enabled sticky event requests an interrupt.
  always_comb begin
    irq_d = |(evt_w & bus.irq_en);
  end

  // Register the request so irq is glitch-free and lags evt by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.level   = level_w;
  assign bus.rise    = rise_w;
  assign bus.fall    = fall_w;
  assign bus.evt     = evt_w;
  assign bus.pending = pending_w;
  assign bus.irq     = irq_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// Testbench for gpio_debounce: one instance with DEBOUNCE_CYCLES=4 (index 0)
// and one with DEBOUNCE_CYCLES=1 (index 1), both 2x32 bits. A behavioural
// model predicts every output each cycle; directed phases add literal checks.
module tb_gpio_debounce;

  localparam int NB = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus variables ----------------
  logic [NB-1:0] pin_v [2];
  logic [NB-1:0] clr_v [2];
  logic [NB-1:0] en_v  [2];
  logic          tick_v[2];
  int            tick_mode[2];   // 0: always 1, 1: every 4th cycle, 2: random
  int            cyc = 0;

  gpio_debounce_if #(.CHANNELS(2), .WIDTH(32)) ifa ();
  gpio_debounce_if #(.CHANNELS(2), .WIDTH(32)) ifb ();

  assign ifa.tick    = tick_v[0];
  assign ifa.pin     = pin_v[0];
  assign ifa.evt_clr = clr_v[0];
  assign ifa.irq_en  = en_v[0];
  assign ifb.tick    = tick_v[1];
  assign ifb.pin     = pin_v[1];
  assign ifb.evt_clr = clr_v[1];
  assign ifb.irq_en  = en_v[1];

  gpio_debounce #(.CHANNELS(2), .WIDTH(32), .DEBOUNCE_CYCLES(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  gpio_debounce #(.CHANNELS(2), .WIDTH(32), .DEBOUNCE_CYCLES(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  logic [NB-1:0] d_level[2];
  logic [NB-1:0] d_rise [2];
  logic [NB-1:0] d_fall [2];
  logic [NB-1:0] d_evt  [2];
  logic          d_irq  [2];

  assign d_level[0] = ifa.level;
  assign d_rise[0]  = ifa.rise;
  assign d_fall[0]  = ifa.fall;
  assign d_evt[0]   = ifa.evt;
  assign d_irq[0]   = ifa.irq;
  assign d_level[1] = ifb.level;
  assign d_rise[1]  = ifb.rise;
  assign d_fall[1]  = ifb.fall;
  assign d_evt[1]   = ifb.evt;
  assign d_irq[1]   = ifb.irq;

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The pad is seen two edges late. A bit's accepted level flips once the
  // delayed pad has disagreed with it for N ticks in a row, where any cycle of
  // agreement restarts the run. Pulses, sticky flags and irq follow from that.
  bit [NB-1:0] m_s1[2], m_s2[2], m_lvl[2], m_rise[2], m_fall[2], m_evt[2];
  bit          m_irq[2];
  int          m_run[2][NB];
  logic [4*NB:0] exp_q[$];

  function automatic int nval(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit [NB-1:0] nl, nr, nf, ne;
      bit          ni;
      ni = |(m_evt[d] & en_v[d]);
      ne = (m_evt[d] & ~clr_v[d]) | m_rise[d] | m_fall[d];
      nl = m_lvl[d];
      nr = '0;
      nf = '0;
      for (int i = 0; i < NB; i++) begin
        if (m_s2[d][i] == m_lvl[d][i]) begin
          m_run[d][i] = 0;
        end else if (tick_v[d]) begin
          m_run[d][i] = m_run[d][i] + 1;
          if (m_run[d][i] >= nval(d)) begin
            nl[i] = m_s2[d][i];
            nr[i] = m_s2[d][i];
            nf[i] = ~m_s2[d][i];
            m_run[d][i] = 0;
          end
        end
      end
      if (rst) begin
        for (int i = 0; i < NB; i++) m_run[d][i] = 0;
        m_lvl[d] = '0; m_rise[d] = '0; m_fall[d] = '0; m_evt[d] = '0; m_irq[d] = 1'b0;
        m_s2[d] = '0;  m_s1[d] = '0;
      end else begin
        m_lvl[d] = nl; m_rise[d] = nr; m_fall[d] = nf; m_evt[d] = ne; m_irq[d] = ni;
        m_s2[d] = m_s1[d];
        m_s1[d] = pin_v[d];
      end
      exp_q.push_back({m_lvl[d], m_rise[d], m_fall[d], m_evt[d], m_irq[d]});
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare process: every cycle, both instances, all outputs.
  initial begin
    logic [4*NB:0] e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("level[%0d]", d), d_level[d], e[4*NB:3*NB+1]);
          chk($sformatf("rise[%0d]", d),  d_rise[d],  e[3*NB:2*NB+1]);
          chk($sformatf("fall[%0d]", d),  d_fall[d],  e[2*NB:NB+1]);
          chk($sformatf("evt[%0d]", d),   d_evt[d],   e[NB:1]);
          chk($sformatf("irq[%0d]", d),   {63'd0, d_irq[d]}, {63'd0, e[0]});
          chk($sformatf("rise_and_fall[%0d]", d), d_rise[d] & d_fall[d], '0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      case (tick_mode[d])
        0:       tick_v[d] = 1'b1;
        1:       tick_v[d] = ((cyc % 4) == 0);
        default: tick_v[d] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  // Step until a chosen output bit reaches val; k = edges taken, 0 if bound hit.
  task automatic wait_bit(input int d, input int sel, input int idx, input logic val,
                          input int max, input string name, output int k);
    logic obs;
    k = 0;
    for (int i = 1; i <= max; i++) begin
      step();
      obs = (sel == 0) ? d_level[d][idx] : d_fall[d][idx];
      if (obs === val) begin
        k = i;
        break;
      end
    end
    if (k == 0) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_word(input int d, input logic [NB-1:0] val, input int max,
                           input string name, output int k);
    k = 0;
    for (int i = 1; i <= max; i++) begin
      step();
      if (d_level[d] === val) begin
        k = i;
        break;
      end
    end
    if (k == 0) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic chk_all_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      chk({name, "_level"}, d_level[d], '0);
      chk({name, "_rise"},  d_rise[d],  '0);
      chk({name, "_fall"},  d_fall[d],  '0);
      chk({name, "_evt"},   d_evt[d],   '0);
      chk({name, "_irq"},   {63'd0, d_irq[d]}, '0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    for (int d = 0; d < 2; d++) begin
      pin_v[d] = '0; clr_v[d] = '0; en_v[d] = '0; tick_v[d] = 1'b1; tick_mode[d] = 0;
    end
    rst = 1'b1;
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) step();

    // N=4, tick=1: accepted after exactly 6 edges, one-cycle rise, sticky evt.
    pin_v[0][0] = 1'b1;
    wait_bit(0, 0, 0, 1'b1, 20, "lat_n4", k);
    chk("lat_n4", 64'(k), 64'd6);
    chk("rise_at_accept", 64'(d_rise[0][0]), 64'd1);
    step();
    chk("rise_one_cycle", 64'(d_rise[0][0]), 64'd0);
    chk("evt_after_rise", 64'(d_evt[0][0]), 64'd1);

    // Three-cycle pulse on [1][5] is rejected.
    pin_v[0][37] = 1'b1;
    repeat (3) step();
    pin_v[0][37] = 1'b0;
    repeat (12) step();
    chk("short_pulse_level", 64'(d_level[0][37]), 64'd0);
    chk("short_pulse_evt",   64'(d_evt[0][37]),   64'd0);

    // Tick every 4th cycle: 4 ticks of mismatch needed, earliest edge 15.
    tick_mode[0] = 1;
    step();
    pin_v[0][1] = 1'b1;
    repeat (14) step();
    chk("slow_tick_not_yet", 64'(d_level[0][1]), 64'd0);
    wait_bit(0, 0, 1, 1'b1, 6, "slow_tick_accept", k);
    // A one-cycle glitch after 9 high cycles must restart the count.
    pin_v[0][2] = 1'b1;
    repeat (9) step();
    pin_v[0][2] = 1'b0;
    step();
    pin_v[0][2] = 1'b1;
    repeat (14) step();
    chk("glitch_restart", 64'(d_level[0][2]), 64'd0);
    tick_mode[0] = 0;
    wait_bit(0, 0, 2, 1'b1, 10, "glitch_final", k);

    // Sticky event, mask, clear, and clear coincident with a new fall.
    pin_v[0][3] = 1'b1;
    wait_bit(0, 0, 3, 1'b1, 20, "evt3_rise", k);
    step();
    chk("evt3_set", 64'(d_evt[0][3]), 64'd1);
    en_v[0][3] = 1'b1;
    step();
    chk("irq_next_cycle", 64'(d_irq[0]), 64'd1);
    clr_v[0][3] = 1'b1;
    step();
    clr_v[0][3] = 1'b0;
    chk("evt3_cleared", 64'(d_evt[0][3]), 64'd0);
    step();
    chk("irq_dropped", 64'(d_irq[0]), 64'd0);
    pin_v[0][3] = 1'b0;
    wait_bit(0, 1, 3, 1'b1, 20, "evt3_fall", k);
    clr_v[0][3] = 1'b1;
    step();
    clr_v[0][3] = 1'b0;
    chk("set_beats_clear", 64'(d_evt[0][3]), 64'd1);
    step();
    chk("irq_after_fall", 64'(d_irq[0]), 64'd1);

    // Reset mid-count abandons it; full latency after release.
    pin_v[0][4] = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    repeat (2) step();
    chk_all_zero("mid_rst");
    rst = 1'b0;
    wait_bit(0, 0, 4, 1'b1, 20, "post_rst_lat", k);
    chk("post_rst_lat", 64'(k), 64'd6);

    // N=1: all 64 bits together, 3-edge latency, coincident pulses.
    pin_v[1] = '1;
    wait_word(1, '1, 10, "n1_rise_lat", k);
    chk("n1_rise_lat", 64'(k), 64'd3);
    chk("n1_rise_all", d_rise[1], '1);
    chk("n1_no_fall",  d_fall[1], '0);
    pin_v[1] = '0;
    wait_word(1, '0, 10, "n1_fall_lat", k);
    chk("n1_fall_lat", 64'(k), 64'd3);
    chk("n1_fall_all", d_fall[1], '1);
    chk("n1_no_rise",  d_rise[1], '0);

    // Randomized phase: sticky-ish pins, random ticks, sparse clears, masks.
    tick_mode[0] = 2;
    tick_mode[1] = 2;
    for (int c = 0; c < 1500; c++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < NB; i++) begin
          if ($urandom_range(0, 15) == 0) pin_v[d][i] = ~pin_v[d][i];
        end
        clr_v[d] = {$urandom() & $urandom() & $urandom(), $urandom() & $urandom() & $urandom()};
        if ($urandom_range(0, 31) == 0) en_v[d] = {$urandom() & $urandom(), $urandom() & $urandom()};
      end
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
